// File: rtl/ppg_multi_ch_calibrator_if.sv
// Sample stream bundle for ppg_multi_ch_calibrator: raw ADC samples in,
// channel-tagged forwarded samples out.
interface ppg_multi_ch_calibrator_if #(
  parameter int ADC_W = 8,
  parameter int CH_W  = 1
);
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic [ADC_W-1:0] smp_data;
  logic [CH_W-1:0]  smp_ch;
  logic             smp_valid;

  modport master (output adc_data, adc_valid, input smp_data, smp_ch, smp_valid);
  modport slave  (input adc_data, adc_valid, output smp_data, smp_ch, smp_valid);
endinterface

// File: rtl/ppg_multi_ch_calibrator.sv
// Multi-channel PPG LED calibrator: per-channel DC binary search and PGA gain search,
// then round-robin run mode. Optional run-mode DC tracking under macro DC_TRACK_EN.
module ppg_multi_ch_calibrator #(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 8,
  parameter int DAC_W      = 7,
  parameter int PGA_W      = 4,
  parameter int WIN_LOG2   = 5,
  parameter int SETTLE_SMP = 4,
  parameter int SLOT_SMP   = 10,
  parameter int DC_TARGET  = 128,
  parameter int DC_LO      = 120,
  parameter int DC_HI      = 135,
  parameter int CLIP_LO    = 10,
  parameter int CLIP_HI    = 245
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     Find_setting,
  ppg_multi_ch_calibrator_if.slave stream,
  output logic [NUM_CH-1:0]        led_en,
  output logic [DAC_W-1:0]         dc_comp,
  output logic [PGA_W-1:0]         pga_gain,
  output logic                     busy,
  output logic                     calib_done,
  output logic [NUM_CH-1:0]        calib_fail
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = ADC_W + WIN_LOG2;
  localparam int CNT_W = $clog2(SLOT_SMP + 1);
  localparam int BIT_W = (DAC_W > 1) ? $clog2(DAC_W) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_N   = CNT_W'(SETTLE_SMP);
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SLOT_SMP - 1);
  localparam logic [SUM_W-1:0]  SUM_GT_TGT = SUM_W'((DC_TARGET + 1) << WIN_LOG2);
  localparam logic [SUM_W-1:0]  SUM_LO     = SUM_W'(DC_LO << WIN_LOG2);
  localparam logic [SUM_W-1:0]  SUM_GT_HI  = SUM_W'((DC_HI + 1) << WIN_LOG2);
  localparam logic [ADC_W-1:0]  CLIP_LO_V  = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0]  CLIP_HI_V  = ADC_W'(CLIP_HI);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] LED_ONE    = NUM_CH'(1);
  localparam logic [DAC_W-1:0]  DAC_ONE    = DAC_W'(1);
  localparam logic [DAC_W-1:0]  DAC_MSB    = DAC_ONE << (DAC_W - 1);
  localparam logic [BIT_W-1:0]  BIT_TOP    = BIT_W'(DAC_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DC_SEARCH, S_DC_CHECK, S_PGA_SEARCH, S_NEXT_CH, S_RUN
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [BIT_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  smp_cnt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [SUM_W-1:0]  sum;
  logic [ADC_W-1:0]  mn, mx;
  logic [DAC_W-1:0]  dc_store  [NUM_CH];
  logic [PGA_W-1:0]  pga_store [NUM_CH];

  logic              smp_in, settling, win_last, clip, fwd;
  logic [SUM_W-1:0]  sum_nx;
  logic [ADC_W-1:0]  mn_nx, mx_nx;
  logic [DAC_W-1:0]  bit_mask, code_kept, load_dc;
  logic [CH_W-1:0]   ch_nx;

`ifdef DC_TRACK_EN
  logic [SUM_W-1:0]    trk_sum [NUM_CH];
  logic [WIN_LOG2-1:0] trk_cnt [NUM_CH];
  logic [SUM_W-1:0]    trk_sum_nx;
  logic                trk_fire;
  logic [DAC_W-1:0]    trk_code;
`endif

  always_comb begin
    smp_in    = stream.adc_valid && !Find_setting;
    settling  = smp_cnt < SETTLE_N;
    win_last  = win_cnt == '1;
    sum_nx    = sum + SUM_W'(stream.adc_data);
    mn_nx     = (win_cnt == '0 || stream.adc_data < mn) ? stream.adc_data : mn;
    mx_nx     = (win_cnt == '0 || stream.adc_data > mx) ? stream.adc_data : mx;
    clip      = (mn_nx <= CLIP_LO_V) || (mx_nx >= CLIP_HI_V);
    bit_mask  = DAC_ONE << bit_idx;
    // mean > target is tested on the raw sum so no truncated mean is needed
    code_kept = (sum_nx >= SUM_GT_TGT) ? dc_comp : (dc_comp & ~bit_mask);
    ch_nx     = (ch == LAST_CH) ? '0 : ch + 1'b1;
    fwd       = (state == S_RUN) && smp_in && (smp_cnt >= SETTLE_N);
    load_dc   = dc_store[ch_nx];
`ifdef DC_TRACK_EN
    trk_sum_nx = trk_sum[ch] + SUM_W'(stream.adc_data);
    trk_fire   = fwd && (trk_cnt[ch] == '1);
    trk_code   = dc_store[ch];
    if (trk_sum_nx >= SUM_GT_HI && dc_store[ch] != '1)
      trk_code = dc_store[ch] + 1'b1;
    else if (trk_sum_nx < SUM_LO && dc_store[ch] != '0)
      trk_code = dc_store[ch] - 1'b1;
    // single-channel builds reload the same channel on the edge it is updated
    if (trk_fire && ch_nx == ch)
      load_dc = trk_code;
`endif
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      ch                <= '0;
      bit_idx           <= '0;
      smp_cnt           <= '0;
      win_cnt           <= '0;
      sum               <= '0;
      mn                <= '0;
      mx                <= '0;
      dc_store          <= '{default: '0};
      pga_store         <= '{default: '0};
      led_en            <= '0;
      dc_comp           <= '0;
      pga_gain          <= '0;
      busy              <= 1'b0;
      calib_done        <= 1'b0;
      calib_fail        <= '0;
      stream.smp_data   <= '0;
      stream.smp_ch     <= '0;
      stream.smp_valid  <= 1'b0;
`ifdef DC_TRACK_EN
      trk_sum           <= '{default: '0};
      trk_cnt           <= '{default: '0};
`endif
    end else begin
      stream.smp_valid <= 1'b0;
      if (Find_setting) begin
        state      <= S_DC_SEARCH;
        ch         <= '0;
        bit_idx    <= BIT_TOP;
        smp_cnt    <= '0;
        win_cnt    <= '0;
        sum        <= '0;
        led_en     <= LED_ONE;
        dc_comp    <= DAC_MSB;
        pga_gain   <= '0;
        busy       <= 1'b1;
        calib_done <= 1'b0;
        calib_fail <= '0;
`ifdef DC_TRACK_EN
        trk_sum    <= '{default: '0};
        trk_cnt    <= '{default: '0};
`endif
      end else begin
        case (state)
          S_IDLE: ;
          S_DC_SEARCH, S_DC_CHECK, S_PGA_SEARCH: begin
            if (smp_in) begin
              if (settling) begin
                smp_cnt <= smp_cnt + 1'b1;
              end else if (!win_last) begin
                win_cnt <= win_cnt + 1'b1;
                sum     <= sum_nx;
                mn      <= mn_nx;
                mx      <= mx_nx;
              end else begin
                // window complete: every outcome changes an output, so re-settle
                smp_cnt <= '0;
                win_cnt <= '0;
                sum     <= '0;
                case (state)
                  S_DC_SEARCH: begin
                    if (bit_idx == '0) begin
                      dc_comp <= code_kept;
                      state   <= S_DC_CHECK;
                    end else begin
                      dc_comp <= code_kept | (bit_mask >> 1);
                      bit_idx <= bit_idx - 1'b1;
                    end
                  end
                  S_DC_CHECK: begin
                    if (sum_nx < SUM_LO || sum_nx >= SUM_GT_HI)
                      calib_fail[ch] <= 1'b1;
                    dc_store[ch] <= dc_comp;
                    pga_gain     <= '0;
                    state        <= S_PGA_SEARCH;
                  end
                  default: begin
                    if (!clip && pga_gain != '1) begin
                      pga_gain <= pga_gain + 1'b1;
                    end else begin
                      if (!clip)
                        pga_store[ch] <= pga_gain;
                      else if (pga_gain != '0)
                        pga_store[ch] <= pga_gain - 1'b1;
                      else begin
                        pga_store[ch]  <= '0;
                        calib_fail[ch] <= 1'b1;
                      end
                      state <= S_NEXT_CH;
                    end
                  end
                endcase
              end
            end
          end
          S_NEXT_CH: begin
            if (ch == LAST_CH) begin
              state      <= S_RUN;
              ch         <= '0;
              led_en     <= LED_ONE;
              dc_comp    <= dc_store[0];
              pga_gain   <= pga_store[0];
              busy       <= 1'b0;
              calib_done <= 1'b1;
              smp_cnt    <= '0;
            end else begin
              state    <= S_DC_SEARCH;
              ch       <= ch_nx;
              led_en   <= LED_ONE << ch_nx;
              dc_comp  <= DAC_MSB;
              pga_gain <= '0;
              bit_idx  <= BIT_TOP;
            end
          end
          S_RUN: begin
            if (smp_in) begin
              if (fwd) begin
                stream.smp_valid <= 1'b1;
                stream.smp_data  <= stream.adc_data;
                stream.smp_ch    <= ch;
              end
              if (smp_cnt == SLOT_LAST) begin
                smp_cnt  <= '0;
                ch       <= ch_nx;
                led_en   <= LED_ONE << ch_nx;
                dc_comp  <= load_dc;
                pga_gain <= pga_store[ch_nx];
              end else begin
                smp_cnt <= smp_cnt + 1'b1;
              end
            end
`ifdef DC_TRACK_EN
            if (fwd) begin
              if (trk_fire) begin
                dc_store[ch] <= trk_code;
                trk_sum[ch]  <= '0;
                trk_cnt[ch]  <= '0;
              end else begin
                trk_sum[ch]  <= trk_sum_nx;
                trk_cnt[ch]  <= trk_cnt[ch] + 1'b1;
              end
            end
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppg_multi_ch_calibrator.sv
// Self-checking bench for ppg_multi_ch_calibrator (NUM_CH=2) with an LED/PGA plant model
// and an arithmetic reference of the calibration outcome.
module tb_ppg_multi_ch_calibrator;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       Find_setting;
  logic [1:0] led_en;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic       busy;
  logic       calib_done;
  logic [1:0] calib_fail;

  ppg_multi_ch_calibrator_if #(.ADC_W(8), .CH_W(1)) bus ();

  ppg_multi_ch_calibrator #(.NUM_CH(2)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .Find_setting (Find_setting),
    .stream       (bus),
    .led_en       (led_en),
    .dc_comp      (dc_comp),
    .pga_gain     (pga_gain),
    .busy         (busy),
    .calib_done   (calib_done),
    .calib_fail   (calib_fail)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int base [2];
  int exp_dc [2];
  int exp_g [2];
  logic [1:0] exp_fail;
  bit phase = 1'b0;
  int exp_tr[$];
  int obs_tr[$];
  int last_dc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Plant: signal alternates mean +/- 10*(gain+1), so any 32-sample window holds 16 of each.
  function automatic int wmean(input int b, input int dc, input int g);
    int m;
    int a;
    m = b - dc;
    a = 10 * (g + 1);
    return (16 * clamp8(m + a) + 16 * clamp8(m - a)) >> 5;
  endfunction

  function automatic bit wclip(input int b, input int dc, input int g);
    int m;
    int a;
    m = b - dc;
    a = 10 * (g + 1);
    return (clamp8(m - a) <= 10) || (clamp8(m + a) >= 245);
  endfunction

  task automatic model_ch(input int b, input bit rec, output int dc, output int g, output bit fail);
    int code;
    int t;
    code = 0;
    t = 0;
    if (rec) exp_tr.delete();
    for (int k = 6; k >= 0; k--) begin
      t = code | (1 << k);
      if (rec) exp_tr.push_back(t);
      if (wmean(b, t, 0) > 128) code = t;
    end
    if (rec && code != t) exp_tr.push_back(code);
    dc = code;
    fail = (wmean(b, code, 0) < 120) || (wmean(b, code, 0) > 135);
    g = 0;
    while (1) begin
      if (wclip(b, code, g)) begin
        if (g == 0) fail = 1'b1;
        else g = g - 1;
        break;
      end
      if (g == 15) break;
      g++;
    end
  endtask

  task automatic tick(input bit v, input bit fs);
    int c;
    int m;
    int a;
    @(negedge CLK);
    Find_setting  = fs;
    bus.adc_valid = v;
    c = (led_en == 2'b10) ? 1 : 0;
    m = base[c] - int'(dc_comp);
    a = 10 * (int'(pga_gain) + 1);
    bus.adc_data = 8'(clamp8(phase ? m + a : m - a));
    if (v) phase = !phase;
    @(posedge CLK);
    #1;
  endtask

  task automatic record_dc();
    if (led_en == 2'b01 && int'(dc_comp) != last_dc) begin
      obs_tr.push_back(int'(dc_comp));
      last_dc = int'(dc_comp);
    end
  endtask

  task automatic calibrate(input bit restart_mid);
    int dc0, g0, dc1, g1;
    bit f0, f1, done, restarted;
    model_ch(base[0], 1'b1, dc0, g0, f0);
    model_ch(base[1], 1'b0, dc1, g1, f1);
    exp_dc[0] = dc0; exp_dc[1] = dc1;
    exp_g[0]  = g0;  exp_g[1]  = g1;
    exp_fail  = {f1, f0};
    obs_tr.delete();
    last_dc = 0;
    tick(1'b1, 1'b1);
    check("start_busy", busy, 1);
    check("start_dc", dc_comp, 64);
    check("start_led", led_en, 1);
    check("start_done", calib_done, 0);
    check("start_fail", calib_fail, 0);
    record_dc();
    done = 1'b0;
    restarted = 1'b0;
    for (int i = 0; i < 30000 && !done; i++) begin
      if (restart_mid && !restarted && led_en == 2'b01 && pga_gain == 4'd3) begin
        tick(1'b1, 1'b1);
        restarted = 1'b1;
        check("restart_dc", dc_comp, 64);
        check("restart_led", led_en, 1);
        check("restart_pga", pga_gain, 0);
        check("restart_busy", busy, 1);
        obs_tr.delete();
        last_dc = 0;
      end else begin
        tick($urandom_range(0, 3) != 0, 1'b0);
      end
      record_dc();
      done = calib_done;
    end
    check("calib_finished", done, 1);
    if (restart_mid) check("restart_taken", restarted, 1);
    check("busy_after", busy, 0);
    check("calib_fail", calib_fail, exp_fail);
    check("trial_count", obs_tr.size(), exp_tr.size());
    for (int i = 0; i < exp_tr.size() && i < obs_tr.size(); i++)
      check("trial_code", obs_tr[i], exp_tr[i]);
  endtask

  task automatic run_check(input int nsamp);
    int k;
    int cur;
    bit v;
    logic [7:0] d;
    k = 0;
    check("run_led0", led_en, 1);
    check("run_dc0", dc_comp, exp_dc[0]);
    check("run_pga0", pga_gain, exp_g[0]);
    for (int i = 0; i < nsamp * 8 && k < nsamp; i++) begin
      v = $urandom_range(0, 2) != 0;
      tick(v, 1'b0);
      d = bus.adc_data;
      if (v) begin
        if (k % 10 >= 4) begin
          check("smp_valid", bus.smp_valid, 1);
          check("smp_data", bus.smp_data, d);
          check("smp_ch", bus.smp_ch, (k / 10) % 2);
        end else begin
          check("smp_settle", bus.smp_valid, 0);
        end
        k++;
      end else begin
        check("smp_gap", bus.smp_valid, 0);
      end
      cur = (k / 10) % 2;
      check("run_led", led_en, 1 << cur);
      check("run_dc", dc_comp, exp_dc[cur]);
      check("run_pga", pga_gain, exp_g[cur]);
      check("run_done", calib_done, 1);
    end
    check("run_samples", k, nsamp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"}, led_en, 0);
    check({tag, "_dc"}, dc_comp, 0);
    check({tag, "_pga"}, pga_gain, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, calib_done, 0);
    check({tag, "_fail"}, calib_fail, 0);
    check({tag, "_sv"}, bus.smp_valid, 0);
    check({tag, "_sd"}, bus.smp_data, 0);
    check({tag, "_sc"}, bus.smp_ch, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    Find_setting = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    base[0] = 190;
    base[1] = 10;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK) rst_n = 1'b1;
    repeat (3) tick(1'b1, 1'b0);
    check("idle_led", led_en, 0);
    check("idle_busy", busy, 0);
    check("idle_sv", bus.smp_valid, 0);

    calibrate(1'b0);
    run_check(60);

    base[0] = $urandom_range(160, 230);
    base[1] = $urandom_range(0, 255);
    calibrate(1'b1);
    run_check(48);

    @(posedge CLK);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge CLK) rst_n = 1'b1;

    base[0] = $urandom_range(0, 255);
    base[1] = $urandom_range(0, 255);
    calibrate(1'b0);
    run_check(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ppg_multi_ch_calibrator.md
Name: ppg_multi_ch_calibrator

Overview:
Parametrised successor to the two-LED (RED/IR) calibration controller in the PPG front-end. It drives NUM_CH LED channels one at a time. For each channel it finds a DC-compensation code by MSB-first binary search, then the largest non-clipping PGA gain. It then enters a run mode that time-multiplexes the channels with their stored settings and tags each ADC sample with its channel ID.

Parameters:
NUM_CH, 2, number of LED channels (1..8); CH_W = max(1, clog2(NUM_CH))
ADC_W, 8, ADC sample width
DAC_W, 7, DC-compensation code width
PGA_W, 4, PGA gain code width
WIN_LOG2, 5, measurement window = 2^WIN_LOG2 valid samples
SETTLE_SMP, 4, valid samples discarded after any LED/DC/PGA change
SLOT_SMP, 10, valid samples per channel slot in run mode (must be > SETTLE_SMP)
DC_TARGET, 128, binary-search target mean
DC_LO, 120, lower bound of accepted DC mean
DC_HI, 135, upper bound of accepted DC mean
CLIP_LO, 10, clip if window min <= CLIP_LO
CLIP_HI, 245, clip if window max >= CLIP_HI

Ports:
CLK  in  1  single clock, rising-edge
rst_n  in  1  asynchronous active-low reset
Find_setting  in  1  synchronous start/restart pulse
adc_data  in  ADC_W  ADC sample
adc_valid  in  1  adc_data valid this cycle
led_en  out  NUM_CH  one-hot LED enable, all-zero when idle
dc_comp  out  DAC_W  DC-compensation DAC code
pga_gain  out  PGA_W  PGA gain code
busy  out  1  high during calibration
calib_done  out  1  high in run mode
calib_fail  out  NUM_CH  per-channel failure flags, sticky until next start
smp_data  out  ADC_W  forwarded sample in run mode
smp_ch  out  CH_W  channel ID of smp_data
smp_valid  out  1  one-cycle strobe qualifying smp_data/smp_ch

Behaviour:
- Reset values: all outputs 0, state IDLE, all stored per-channel DC/PGA registers 0.
- Measurement window:
  - First discard SETTLE_SMP valid samples.
  - Then accumulate 2^WIN_LOG2 valid samples into a sum of ADC_W+WIN_LOG2 bits, and track min/max.
  - mean = sum >> WIN_LOG2.
  - Cycles without adc_valid are ignored.
- States:
  - IDLE -> DC_SEARCH on Find_setting. Sets ch=0, busy=1, calib_fail cleared.
  - DC_SEARCH: bit k runs from DAC_W-1 down to 0. Trial code = code | (1<<k). Run one window. Keep bit iff mean > DC_TARGET. After bit 0, go to DC_CHECK.
  - DC_CHECK: run one window at the final code. Set calib_fail[ch] if mean < DC_LO or mean > DC_HI. Store the code; go to PGA_SEARCH with gain=0.
  - PGA_SEARCH: run one window.
    - No clip and gain < max: gain+1, repeat.
    - No clip at max: store max.
    - Clip at gain g > 0: store g-1.
    - Clip at gain 0: store 0 and set calib_fail[ch].
    - Then go to NEXT_CH.
  - NEXT_CH: ch+1 -> DC_SEARCH (code reset to 0). After the last channel -> RUN, with busy=0 and calib_done=1.
  - RUN: round-robin slots ch=0..NUM_CH-1, wrapping.
    - Slot entry: in the same cycle, load led_en/dc_comp/pga_gain from the stored values.
    - Discard SETTLE_SMP samples, then forward the remaining SLOT_SMP-SETTLE_SMP samples: smp_valid one cycle after the adc_valid cycle, with smp_ch=ch.
- led_en = one-hot(ch) in every state except IDLE.
- dc_comp/pga_gain in calibration: dc_comp is the trial/final code throughout DC_SEARCH/DC_CHECK and stays at the final code through PGA_SEARCH; pga_gain is 0 during DC_SEARCH/DC_CHECK and the current gain in PGA_SEARCH.
- Any output change restarts the settle discard.
- Find_setting in any non-IDLE state (including mid-window or RUN): restart at DC_SEARCH ch=0 next cycle, clear accumulators and calib_fail, and set calib_done=0.
- Find_setting together with adc_valid: the sample is discarded.
- rst_n low at any time: immediate return to reset values; in-progress results are lost.
- Arithmetic: trial code saturates within DAC_W; gain increments never wrap past 2^PGA_W-1.

Optional Feature:
Macro DC_TRACK_EN.
- Defined: in RUN, each channel accumulates its forwarded samples into a 2^WIN_LOG2 window.
  - Mean > DC_HI: stored dc code +1, saturating at max.
  - Mean < DC_LO: stored dc code -1, saturating at 0.
  - The updated code applies from that channel's next slot.
- Not defined: stored codes are frozen in RUN; no tracking logic is present.

Test Plan:
- Bench plant model: mean = base_ch - dc_comp; signal = mean ± 10*(pga_gain+1). NUM_CH=2.
- DC search, ch0 base 190: Find_setting -> trial sequence 64, 32, 48, 56, 60, 62, 61. Final dc=61, mean 129, calib_fail[0]=0.
- PGA search, ch0: gain steps 0..11; clip at 11 (max 249). Stored gain=10; ch1 searched next with led_en=2'b10.
- Fail path, ch1 base 10: binary search ends at dc=0, mean 10 < DC_LO -> calib_fail[1]=1. Calibration still completes and calib_done=1.
- Run mode, adc_valid every cycle: smp_ch pattern 0×6, 1×6 repeating. dc_comp/pga_gain switch at each slot boundary. No smp_valid during the first 4 samples of each slot.
- Restart/reset:
  - Find_setting mid-PGA_SEARCH -> next cycle DC_SEARCH ch=0, dc_comp=64.
  - rst_n low mid-RUN -> all outputs 0 asynchronously.
- DC_TRACK_EN defined, ch0 base drifts from 190 to 200 in RUN: after each full window the stored dc increments by 1 until mean ≤ 135.
